rr_grant_scheduler: RTL and testbench
=====================================

RR_GRANT_SCHEDULER -- requirements
Module: rr_grant_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the number of requesters sharing the resource (N >= 2).
REQ-002 The block SHALL have parameter MAX_HOLD, default 16, giving the maximum consecutive grant cycles per owner (MAX_HOLD >= 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: when high, new grants may be issued.
REQ-006 The block SHALL have port req, input, N bits: one request line per requester.
REQ-007 The block SHALL have port gnt, output, N bits: one-hot grant, all-zero when idle.
REQ-008 The block SHALL have port gnt_id, output, clog2(N) bits: binary index of the current owner, 0 when idle.
REQ-009 The block SHALL have port busy, output, 1 bit: high while any grant is held.
REQ-010 The block SHALL have port expired, output, 1 bit: one-cycle pulse when a grant is force-released by hold expiry.

Function
REQ-011 The block SHALL keep a one-hot N-bit priority pointer ptr; the position of its set bit is the highest-priority requester.
REQ-012 The FSM SHALL have two states, IDLE and GRANT.
REQ-013 In IDLE with en=1 and req!=0, the block SHALL select the first set req bit at or above the ptr position, wrapping from bit N-1 to bit 0, and enter GRANT.
REQ-014 gnt, gnt_id and busy SHALL be registered outputs; a grant SHALL appear exactly 1 cycle after the sampling edge in REQ-013.
REQ-015 In IDLE with en=0 or req=0, gnt SHALL remain zero and ptr SHALL be unchanged.
REQ-016 In GRANT, gnt SHALL be held constant; req changes on non-owner lines SHALL have no effect.
REQ-017 A hold counter, clog2(MAX_HOLD) bits wide, SHALL clear on grant issue and increment each GRANT cycle.
REQ-018 Release SHALL occur when the owner's req bit is sampled low, or when the counter equals MAX_HOLD-1 (expiry).
REQ-019 On release, the block SHALL return to IDLE with gnt cleared next cycle and ptr set to the owner's grant rotated left by one (owner+1, bit N-1 wraps to bit 0).
REQ-020 Consecutive grants SHALL always be separated by one IDLE cycle (gnt=0).
REQ-021 expired SHALL pulse for exactly one cycle, coincident with the first gnt=0 cycle, only for expiry release.
REQ-022 If owner req drops on the same edge as expiry, the release SHALL be treated as voluntary; expired SHALL stay low.
REQ-023 en going low during GRANT SHALL NOT revoke the current grant; it SHALL only block the next issue.
REQ-024 An expired owner still requesting SHALL be arbitrated normally and rank after all other requesters, because ptr has moved past it.

Reset
REQ-025 On reset low, asynchronously: state=IDLE, gnt=0, gnt_id=0, busy=0, expired=0, counter=0, ptr=bit 0 set.
REQ-026 Reset asserted mid-grant SHALL drop gnt immediately without waiting for a clock edge.
REQ-027 After reset deasserts, the first arbitration SHALL give requester 0 highest priority.

Structure
REQ-028 The package rr_sched_pkg SHALL hold the state enumeration (IDLE, GRANT) and default constants for N and MAX_HOLD.
REQ-029 The block SHALL instantiate one combinational sub-module, rr_priority_pick (inputs req and ptr, output one-hot pick), which may be reused elsewhere.

Verification
REQ-030 Reset, then req=8'h81 held -> gnt=8'h01, gnt_id=0 one cycle later; owner drops req -> gnt=0 for 1 cycle, then gnt=8'h80, gnt_id=7.
REQ-031 Owner 3 holds req continuously with MAX_HOLD=16 and req=8'h28 -> gnt=8'h08 for exactly 16 cycles, then expired=1 for 1 cycle with gnt=0, then gnt=8'h20.
REQ-032 Wrap check: owner 7 releases, req=8'h02 -> ptr=8'h01, next gnt=8'h02.
REQ-033 Hold owner req until the expiry edge, dropping it on that same edge -> gnt releases with expired=0.
REQ-034 en=0 with req=8'hFF -> gnt stays 0; en low during a grant -> grant persists until release and no new grant follows.
REQ-035 Assert reset low mid-grant between clock edges -> gnt=0 and busy=0 immediately; after deassertion with req=8'hFF -> gnt=8'h01.

Source files
------------

// File: rtl/rr_grant_scheduler_pkg.sv
// rr_sched_pkg: FSM state encoding and default sizing for the round-robin grant scheduler
package rr_sched_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int N_DEF = 8;
  localparam int MAX_HOLD_DEF = 16;
endpackage

// File: rtl/rr_grant_scheduler_if.sv
// rr_grant_scheduler_if: request/grant bundle between requesters (master) and the scheduler (slave)
//   en, req          : issue enable and per-requester request lines, driven by master
//   gnt, gnt_id      : one-hot grant and its binary index, driven by slave
//   busy, expired    : grant-held flag and hold-expiry release pulse, driven by slave
interface rr_grant_scheduler_if
  import rr_sched_pkg::*;
#(parameter int N = N_DEF);
  logic en;
  logic [N-1:0] req, gnt;
  logic [$clog2(N)-1:0] gnt_id;
  logic busy, expired;
  modport master(output en, req, input gnt, gnt_id, busy, expired);
  modport slave(input en, req, output gnt, gnt_id, busy, expired);
endinterface

// File: rtl/rr_grant_scheduler_pick.sv
// rr_priority_pick: combinational round-robin pick of the first req bit at or above one-hot ptr, wrapping
//   req  : request vector
//   ptr  : one-hot highest-priority position
//   pick : one-hot selected requester, zero when req is zero
module rr_priority_pick #(parameter int N = 8) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] pick
);
  logic [2*N-1:0] dbl, iso;
  // Doubling req lets a plain lowest-set-bit search wrap past bit N-1.
  assign dbl = {req, req} & ~({{N{1'b0}}, ptr} - (2*N)'(1));
  assign iso = dbl & (~dbl + (2*N)'(1));
  assign pick = iso[N-1:0] | iso[2*N-1:N];
endmodule

// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler: round-robin arbiter with registered one-hot grant and bounded hold time
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of rr_grant_scheduler_if (en, req in; gnt, gnt_id, busy, expired out)
module rr_grant_scheduler
  import rr_sched_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input logic clk,
  input logic reset,
  rr_grant_scheduler_if.slave bus
);
  localparam int W = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD);
  state_t state;
  logic [N-1:0] ptr, pick;
  logic [W-1:0] pick_id;
  logic [CW-1:0] cnt;
  logic own_req, at_max;
  rr_priority_pick #(.N(N)) u_pick (.req(bus.req), .ptr(ptr), .pick(pick));
  always_comb begin
    pick_id = '0;
    for (int i = 0; i < N; i++) if (pick[i]) pick_id = W'(i);
  end
  assign own_req = |(bus.req & bus.gnt);
  assign at_max = cnt == CW'(MAX_HOLD - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      bus.gnt <= '0;
      bus.gnt_id <= '0;
      bus.busy <= 1'b0;
      bus.expired <= 1'b0;
      cnt <= '0;
      ptr <= N'(1);
    end else if (state == IDLE) begin
      bus.expired <= 1'b0;
      if (bus.en && |bus.req) begin
        state <= GRANT;
        bus.gnt <= pick;
        bus.gnt_id <= pick_id;
        bus.busy <= 1'b1;
        cnt <= '0;
      end
    end else if (!own_req || at_max) begin
      // A dropped request wins over expiry on the same edge, so expired is only set while req is still high.
      state <= IDLE;
      bus.gnt <= '0;
      bus.gnt_id <= '0;
      bus.busy <= 1'b0;
      bus.expired <= own_req;
      ptr <= {bus.gnt[N-2:0], bus.gnt[N-1]};
    end else
      cnt <= cnt + CW'(1);
endmodule

// File: tb/tb_rr_grant_scheduler.sv
// tb_rr_grant_scheduler: directed self-checking bench for rr_grant_scheduler
module tb_rr_grant_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int n;
  rr_grant_scheduler_if #(.N(8)) bus ();
  rr_grant_scheduler #(.N(8), .MAX_HOLD(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  initial begin
    bus.en = 1'b0;
    bus.req = 8'h00;
    #12;
    chk("rst_gnt", 32'(bus.gnt), 32'h00);
    chk("rst_id", 32'(bus.gnt_id), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_exp", 32'(bus.expired), 32'h0);
    step();
    reset = 1'b1;
    bus.en = 1'b1;
    bus.req = 8'h81;
    step();
    chk("first_gnt", 32'(bus.gnt), 32'h01);
    chk("first_id", 32'(bus.gnt_id), 32'h0);
    chk("first_busy", 32'(bus.busy), 32'h1);
    bus.req = 8'h80;
    step();
    chk("gap_gnt", 32'(bus.gnt), 32'h00);
    chk("gap_exp", 32'(bus.expired), 32'h0);
    step();
    chk("second_gnt", 32'(bus.gnt), 32'h80);
    chk("second_id", 32'(bus.gnt_id), 32'h7);
    bus.req = 8'h02;
    step();
    chk("wrap_gap", 32'(bus.gnt), 32'h00);
    bus.req = 8'h82;
    step();
    chk("wrap_gnt", 32'(bus.gnt), 32'h02);
    chk("wrap_id", 32'(bus.gnt_id), 32'h1);
    bus.req = 8'h00;
    step();
    chk("idle_gnt", 32'(bus.gnt), 32'h00);
    bus.req = 8'h28;
    step();
    n = 0;
    while (bus.gnt == 8'h08 && n < 40) begin
      n++;
      step();
    end
    chk("hold_len", 32'(n), 32'd16);
    chk("exp_pulse", 32'(bus.expired), 32'h1);
    chk("exp_gnt", 32'(bus.gnt), 32'h00);
    chk("exp_busy", 32'(bus.busy), 32'h0);
    step();
    chk("after_exp_gnt", 32'(bus.gnt), 32'h20);
    chk("after_exp_pulse", 32'(bus.expired), 32'h0);
    chk("after_exp_id", 32'(bus.gnt_id), 32'h5);
    for (int i = 0; i < 15; i++) step();
    chk("pre_expiry_gnt", 32'(bus.gnt), 32'h20);
    bus.req = 8'h00;
    step();
    chk("vol_gnt", 32'(bus.gnt), 32'h00);
    chk("vol_exp", 32'(bus.expired), 32'h0);
    bus.en = 1'b0;
    bus.req = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en0_gnt", 32'(bus.gnt), 32'h00);
    end
    chk("en0_busy", 32'(bus.busy), 32'h0);
    bus.en = 1'b1;
    step();
    chk("en1_gnt", 32'(bus.gnt), 32'h40);
    chk("en1_id", 32'(bus.gnt_id), 32'h6);
    bus.en = 1'b0;
    step();
    chk("en_drop_keep", 32'(bus.gnt), 32'h40);
    step();
    chk("en_drop_keep2", 32'(bus.gnt), 32'h40);
    bus.req = 8'hBF;
    step();
    chk("en_drop_rel", 32'(bus.gnt), 32'h00);
    step();
    chk("en_drop_block", 32'(bus.gnt), 32'h00);
    step();
    chk("en_drop_block2", 32'(bus.busy), 32'h0);
    bus.en = 1'b1;
    step();
    chk("pre_rst_gnt", 32'(bus.gnt), 32'h80);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(bus.gnt), 32'h00);
    chk("async_rst_busy", 32'(bus.busy), 32'h0);
    bus.req = 8'hFF;
    step();
    reset = 1'b1;
    step();
    chk("post_rst_gnt", 32'(bus.gnt), 32'h01);
    chk("post_rst_id", 32'(bus.gnt_id), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
